// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up sequencer: isolation release, PLL lock, CDR lock and word
// alignment with per-stage timeouts and bounded retries, in the 24 MHz reference domain.
module serdesphy_link_seq #(
  parameter int SETTLE_CYC    = 64,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_STABLE   = 8,
  parameter int PLL_TIMEOUT   = 24000,
  parameter int CDR_TIMEOUT   = 24000,
  parameter int ALIGN_TIMEOUT = 4800,
  parameter int MAX_RETRY     = 3,
  parameter int TIMER_W       = 16
) (
  input  logic       clk_ref_24m,
  input  logic       rst,
  input  logic       seq_en,
  input  logic       power_good,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       rx_aligned,
  output logic       iso_en,
  output logic       pll_rst,
  output logic       cdr_rst,
  output logic       rx_align_rst,
  output logic       tx_en,
  output logic       rx_en,
  output logic       link_up,
  output logic       link_fail,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR      = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_CDR_WAIT = 3'd3,
    ST_ALIGN    = 3'd4,
    ST_UP       = 3'd5,
    ST_FAIL     = 3'd6,
    ST_RETRY    = 3'd7
  } state_t;

  localparam int STAB_W = (LOCK_STABLE < 2) ? 1 : $clog2(LOCK_STABLE + 1);

  localparam logic [TIMER_W-1:0] SETTLE_END = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] RST_END    = TIMER_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] PLL_END    = TIMER_W'(PLL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] CDR_END    = TIMER_W'(CDR_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ALIGN_END  = TIMER_W'(ALIGN_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_END   = STAB_W'(LOCK_STABLE - 1);
  localparam logic [1:0]         RETRY_MAX  = 2'(MAX_RETRY);

  state_t              state;
  state_t              next_state;
  logic [TIMER_W-1:0]  timer;
  logic [STAB_W-1:0]   stab_cnt;
  logic [2:0]          sync_p0;
  logic [2:0]          sync_p1;
  logic                pll_s;
  logic                cdr_s;
  logic                align_s;
  logic                retry_req;

  // Output vector order: {iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail}
  function automatic logic [7:0] decode_outs(input state_t s);
    logic [7:0] o;
    o = 8'b1111_0000;
    case (s)
      ST_PWR:      o = 8'b0111_0000;
      ST_PLL_WAIT: o = 8'b0011_0000;
      ST_CDR_WAIT: o = 8'b0001_1100;
      ST_ALIGN:    o = 8'b0000_1100;
      ST_UP:       o = 8'b0000_1110;
      ST_FAIL:     o = 8'b1111_0001;
      ST_RETRY:    o = 8'b0111_0000;
      default:     o = 8'b1111_0000;
    endcase
    return o;
  endfunction

  // Synchronizer stage 0/1 for the asynchronous PMA/PCS status flags
  always_ff @(posedge clk_ref_24m or posedge rst) begin
    if (rst) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= {rx_aligned, cdr_lock, pll_lock};
      sync_p1 <= sync_p0;
    end
  end

  assign pll_s   = sync_p1[0];
  assign cdr_s   = sync_p1[1];
  assign align_s = sync_p1[2];

  always_comb begin
    next_state = state;
    retry_req  = 1'b0;
    if (!seq_en) begin
      next_state = ST_IDLE;
    end else if (!power_good && state != ST_IDLE && state != ST_FAIL) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (power_good) next_state = ST_PWR;
        ST_PWR:      if (timer == SETTLE_END) next_state = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          if (pll_s && stab_cnt == STAB_END) next_state = ST_CDR_WAIT;
          else if (timer == PLL_END)         retry_req  = 1'b1;
        end
        ST_CDR_WAIT: begin
          if (!pll_s)                retry_req  = 1'b1;
          else if (cdr_s)            next_state = ST_ALIGN;
          else if (timer == CDR_END) retry_req  = 1'b1;
        end
        ST_ALIGN: begin
          if (!pll_s || !cdr_s)        retry_req  = 1'b1;
          else if (align_s)            next_state = ST_UP;
          else if (timer == ALIGN_END) retry_req  = 1'b1;
        end
        ST_UP:       if (!pll_s || !cdr_s || !align_s) retry_req = 1'b1;
        ST_FAIL:     next_state = ST_FAIL;
        ST_RETRY:    if (timer == RST_END) next_state = ST_PLL_WAIT;
        default:     next_state = ST_IDLE;
      endcase
      if (retry_req) next_state = (retry_cnt == RETRY_MAX) ? ST_FAIL : ST_RETRY;
    end
  end

  // Outputs are registered from the next state so they switch together with the state
  always_ff @(posedge clk_ref_24m or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      stab_cnt  <= '0;
      retry_cnt <= 2'd0;
      {iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail} <= decode_outs(ST_IDLE);
    end else begin
      state <= next_state;
      timer <= (next_state != state) ? '0 : timer + TIMER_W'(1);

      if (state != ST_PLL_WAIT || next_state != ST_PLL_WAIT) stab_cnt <= '0;
      else if (pll_s)                                        stab_cnt <= stab_cnt + STAB_W'(1);
      else                                                   stab_cnt <= '0;

      if (next_state == ST_IDLE || next_state == ST_UP)
        retry_cnt <= 2'd0;
      else if (next_state == ST_RETRY && state != ST_RETRY && retry_cnt != 2'd3)
        retry_cnt <= retry_cnt + 2'd1;

      {iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail} <= decode_outs(next_state);
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Directed bench for serdesphy_link_seq with shortened timing parameters: a vector table
// for the main bring-up/retry/fail walks plus hand sequences for glitch, tie and reset.
module tb_serdesphy_link_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seq_en = 1'b0, power_good = 1'b0;
  logic       pll_lock = 1'b0, cdr_lock = 1'b0, rx_aligned = 1'b0;
  logic       iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  int nvec  = 0;
  int nfail = 0;

  serdesphy_link_seq #(
    .SETTLE_CYC(4), .RST_PULSE(2), .LOCK_STABLE(3), .PLL_TIMEOUT(20),
    .CDR_TIMEOUT(20), .ALIGN_TIMEOUT(10), .MAX_RETRY(2), .TIMER_W(16)
  ) dut (
    .clk_ref_24m(clk), .rst(rst), .seq_en(seq_en), .power_good(power_good),
    .pll_lock(pll_lock), .cdr_lock(cdr_lock), .rx_aligned(rx_aligned),
    .iso_en(iso_en), .pll_rst(pll_rst), .cdr_rst(cdr_rst), .rx_align_rst(rx_align_rst),
    .tx_en(tx_en), .rx_en(rx_en), .link_up(link_up), .link_fail(link_fail),
    .seq_state(seq_state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       se, pg, pl, cl, al;
    int         n;
    logic [2:0] st;
    logic [1:0] rc;
  } vec_t;

  vec_t tbl [0:33];

  // Required {iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail} per state
  function automatic logic [7:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd0:    return 8'b1111_0000;
      3'd1:    return 8'b0111_0000;
      3'd2:    return 8'b0011_0000;
      3'd3:    return 8'b0001_1100;
      3'd4:    return 8'b0000_1100;
      3'd5:    return 8'b0000_1110;
      3'd6:    return 8'b1111_0001;
      default: return 8'b0111_0000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] est, input logic [1:0] erc);
    logic [7:0] act_o;
    logic [7:0] exp_o;
    act_o = {iso_en, pll_rst, cdr_rst, rx_align_rst, tx_en, rx_en, link_up, link_fail};
    exp_o = exp_outs(est);
    nvec++;
    if (seq_state !== est || act_o !== exp_o || retry_cnt !== erc) begin
      nfail++;
      $display("FAIL %s: got state=%0d outs=%b retry=%0d, want state=%0d outs=%b retry=%0d",
               name, seq_state, act_o, retry_cnt, est, exp_o, erc);
    end
  endtask

  task automatic drive(input logic se, input logic pg, input logic pl, input logic cl, input logic al);
    seq_en = se; power_good = pg; pll_lock = pl; cdr_lock = cl; rx_aligned = al;
  endtask

  initial begin
    //          se  pg  pl  cl  al   n  st    rc
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,  1, 3'd1, 2'd0}; // nominal: PWR
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,  3, 3'd1, 2'd0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,  1, 3'd2, 2'd0}; // pll_rst drops 5 cycles in
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,  5, 3'd2, 2'd0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,  4, 3'd2, 2'd0};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,  1, 3'd3, 2'd0};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 15, 3'd3, 2'd0};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,  2, 3'd3, 2'd0};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,  1, 3'd4, 2'd0};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,  7, 3'd4, 2'd0};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  2, 3'd4, 2'd0};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd5, 2'd0}; // aligned on the timeout cycle
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  5, 3'd5, 2'd0};
    tbl[13] = '{1'b1,1'b1,1'b1,1'b0,1'b1,  2, 3'd5, 2'd0}; // link drop: cdr_lock falls
    tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b1,  1, 3'd7, 2'd1};
    tbl[15] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd7, 2'd1};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd2, 2'd1};
    tbl[17] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  2, 3'd2, 2'd1};
    tbl[18] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd3, 2'd1};
    tbl[19] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd4, 2'd1};
    tbl[20] = '{1'b1,1'b1,1'b1,1'b1,1'b1,  1, 3'd5, 2'd0}; // relock clears retry_cnt
    tbl[21] = '{1'b0,1'b1,1'b1,1'b1,1'b0,  1, 3'd0, 2'd0}; // seq_en drop
    tbl[22] = '{1'b1,1'b1,1'b1,1'b1,1'b0,  9, 3'd4, 2'd0};
    tbl[23] = '{1'b1,1'b0,1'b1,1'b1,1'b0,  1, 3'd0, 2'd0}; // power_good abort in ALIGN
    tbl[24] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 24, 3'd2, 2'd0}; // PLL never locks
    tbl[25] = '{1'b1,1'b1,1'b0,1'b0,1'b0,  1, 3'd7, 2'd1};
    tbl[26] = '{1'b1,1'b1,1'b0,1'b0,1'b0,  2, 3'd2, 2'd1};
    tbl[27] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 19, 3'd2, 2'd1};
    tbl[28] = '{1'b1,1'b1,1'b0,1'b0,1'b0,  1, 3'd7, 2'd2};
    tbl[29] = '{1'b1,1'b1,1'b0,1'b0,1'b0,  2, 3'd2, 2'd2};
    tbl[30] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 20, 3'd6, 2'd2};
    tbl[31] = '{1'b1,1'b1,1'b0,1'b0,1'b0,  5, 3'd6, 2'd2};
    tbl[32] = '{1'b1,1'b0,1'b0,1'b0,1'b0,  1, 3'd6, 2'd2}; // power_good ignored in FAIL
    tbl[33] = '{1'b0,1'b1,1'b0,1'b0,1'b0,  1, 3'd0, 2'd0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    check("reset", 3'd0, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].se, tbl[i].pg, tbl[i].pl, tbl[i].cl, tbl[i].al);
      step(tbl[i].n);
      check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rc);
    end

    // pll_lock glitch: 2 high, 1 low, then high; only a clean run of 3 advances
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5);
    check("glitch_pllwait", 3'd2, 2'd0);
    step(1);
    pll_lock = 1'b1; step(2);
    pll_lock = 1'b0; step(1);
    pll_lock = 1'b1; step(2);
    check("glitch_no_early_adv", 3'd2, 2'd0);
    step(2);
    check("glitch_hold", 3'd2, 2'd0);
    step(1);
    check("glitch_cdrwait", 3'd3, 2'd0);

    // cdr_lock synced high on the CDR_TIMEOUT cycle: success wins
    step(17);
    cdr_lock = 1'b1;
    step(2);
    check("tie_before", 3'd3, 2'd0);
    step(1);
    check("tie_align", 3'd4, 2'd0);
    rx_aligned = 1'b1;
    step(3);
    check("tie_up", 3'd5, 2'd0);

    // Asynchronous reset in UP takes effect without a clock edge
    rst = 1'b1;
    #2;
    check("rst_mid_up", 3'd0, 2'd0);
    seq_en = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    check("post_rst_idle", 3'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
